gpio_apb_arbiter: RTL and testbench

//  2:1 APB arbiter that shares the single GPIO APB slave port between two APB requesters:
//  in0 is the CPU bridge, in1 is a secondary master (debug/DMA).

---
 rtl/gpio_apb_arbiter_pkg.sv | 22 ++
 rtl/gpio_apb_arbiter_rr_arb2.sv | 22 ++
 rtl/gpio_apb_arbiter.sv | 147 ++++++++++++++
 tb/tb_gpio_apb_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_apb_arbiter_pkg.sv
// Shared types for the GPIO APB 2:1 arbiter: FSM states, latched request
// record and grant identifiers.
package gpio_apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } apb_req_t;

    localparam logic GRANT_IN0 = 1'b0;
    localparam logic GRANT_IN1 = 1'b1;

endpackage

// File: rtl/gpio_apb_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// the requester that was not granted last.
module rr_arb2
    import gpio_apb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_id,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        gnt_id = GRANT_IN0;
        if (req == 2'b11) begin
            gnt_id = ~last;
        end else if (req[1]) begin
            gnt_id = GRANT_IN1;
        end
    end

endmodule

// File: rtl/gpio_apb_arbiter.sv
// Shares the single GPIO APB slave port between the CPU bridge (in0) and a
// secondary master (in1), one transfer at a time, with a hung-slave watchdog.
module gpio_apb_arbiter
    import gpio_apb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] in0_paddr,
    input  logic        in0_psel,
    input  logic        in0_penable,
    input  logic [2:0]  in0_pprot,
    input  logic        in0_pwrite,
    input  logic [31:0] in0_pwdata,
    input  logic [3:0]  in0_pstrb,
    output logic        in0_pready,
    output logic [31:0] in0_prdata,
    output logic        in0_pslverr,

    input  logic [31:0] in1_paddr,
    input  logic        in1_psel,
    input  logic        in1_penable,
    input  logic [2:0]  in1_pprot,
    input  logic        in1_pwrite,
    input  logic [31:0] in1_pwdata,
    input  logic [3:0]  in1_pstrb,
    output logic        in1_pready,
    output logic [31:0] in1_prdata,
    output logic        in1_pslverr,

    output logic [31:0] out_paddr,
    output logic [2:0]  out_pprot,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    output logic        out_psel,
    output logic        out_penable,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr
);

    localparam bit              TO_EN  = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_VAL = TO_W'(TIMEOUT);

    state_t          r_state;
    logic            r_gnt;
    logic            r_last;
    logic [TO_W-1:0] r_wdog;

    apb_req_t    w_req0;
    apb_req_t    w_req1;
    apb_req_t    w_winReq;
    logic        w_gntId;
    logic        w_reqValid;
    logic        w_timeout;
    logic        w_done;
    logic [31:0] w_rspData;
    logic        w_rspErr;
    logic        w_unused;

    assign w_unused = ^{in0_penable, in1_penable};

    assign w_req0 = '{addr: in0_paddr, prot: in0_pprot, write: in0_pwrite,
                      wdata: in0_pwdata, strb: in0_pstrb};
    assign w_req1 = '{addr: in1_paddr, prot: in1_pprot, write: in1_pwrite,
                      wdata: in1_pwdata, strb: in1_pstrb};
    assign w_winReq = (w_gntId == GRANT_IN1) ? w_req1 : w_req0;

    rr_arb2 u_rrArb (
        .req    ({in1_psel, in0_psel}),
        .last   (r_last),
        .gnt_id (w_gntId),
        .valid  (w_reqValid)
    );

    // A real slave response always beats the watchdog in the same cycle.
    assign w_timeout = TO_EN && (r_wdog == TO_VAL);
    assign w_done    = (r_state == ACCESS) && (out_pready || w_timeout);
    assign w_rspData = out_pready ? out_prdata : 32'h0;
    assign w_rspErr  = out_pready ? out_pslverr : 1'b1;

    assign in0_pready  = w_done && (r_gnt == GRANT_IN0);
    assign in1_pready  = w_done && (r_gnt == GRANT_IN1);
    assign in0_prdata  = in0_pready ? w_rspData : 32'h0;
    assign in1_prdata  = in1_pready ? w_rspData : 32'h0;
    assign in0_pslverr = in0_pready && w_rspErr;
    assign in1_pslverr = in1_pready && w_rspErr;

    // Aborted transfers also advance the round-robin pointer so a hung slave
    // cannot lock the other requester out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_gnt       <= GRANT_IN0;
            r_last      <= GRANT_IN1;
            r_wdog      <= '0;
            out_paddr   <= 32'h0;
            out_pprot   <= 3'h0;
            out_pwrite  <= 1'b0;
            out_pwdata  <= 32'h0;
            out_pstrb   <= 4'h0;
            out_psel    <= 1'b0;
            out_penable <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_reqValid) begin
                        out_paddr   <= w_winReq.addr;
                        out_pprot   <= w_winReq.prot;
                        out_pwrite  <= w_winReq.write;
                        out_pwdata  <= w_winReq.wdata;
                        out_pstrb   <= w_winReq.strb;
                        out_psel    <= 1'b1;
                        out_penable <= 1'b0;
                        r_gnt       <= w_gntId;
                        r_state     <= SETUP;
                    end
                end
                SETUP: begin
                    out_penable <= 1'b1;
                    r_wdog      <= '0;
                    r_state     <= ACCESS;
                end
                ACCESS: begin
                    if (w_done) begin
                        out_psel    <= 1'b0;
                        out_penable <= 1'b0;
                        r_last      <= r_gnt;
                        r_state     <= IDLE;
                    end else if (r_wdog != {TO_W{1'b1}}) begin
                        r_wdog <= r_wdog + TO_W'(1);
                    end
                end
                default: begin
                    out_psel    <= 1'b0;
                    out_penable <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Self-checking bench for gpio_apb_arbiter: directed vectors, multi-cycle
// corner sequences and a randomized run against a transaction-level model.
module tb_gpio_apb_arbiter;

    typedef struct {
        bit          req0;
        bit          req1;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic        write0;
        logic        write1;
        int          waits;
        bit          bothServe;
        bit          expFirst;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } txn_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic [31:0] in0_paddr = '0, in1_paddr = '0;
    logic        in0_psel = 1'b0, in1_psel = 1'b0;
    logic        in0_penable = 1'b0, in1_penable = 1'b0;
    logic [2:0]  in0_pprot = '0, in1_pprot = '0;
    logic        in0_pwrite = 1'b0, in1_pwrite = 1'b0;
    logic [31:0] in0_pwdata = '0, in1_pwdata = '0;
    logic [3:0]  in0_pstrb = '0, in1_pstrb = '0;
    logic        in0_pready, in1_pready;
    logic [31:0] in0_prdata, in1_prdata;
    logic        in0_pslverr, in1_pslverr;

    logic [31:0] out_paddr;
    logic [2:0]  out_pprot;
    logic        out_pwrite;
    logic [31:0] out_pwdata;
    logic [3:0]  out_pstrb;
    logic        out_psel, out_penable;
    logic        out_pready = 1'b0;
    logic [31:0] out_prdata = '0;
    logic        out_pslverr = 1'b0;

    int errors = 0;
    int checks = 0;

    int          slaveWait = 0;
    int          curWait = 0;
    bit          randomWaits = 1'b0;
    bit          slaveHang = 1'b0;
    bit          slaveUseFixed = 1'b0;
    bit          slaveErrMode = 1'b0;
    logic [31:0] slaveFixed = '0;

    always #5 clock = ~clock;

    gpio_apb_arbiter #(.TIMEOUT(4), .TO_W(3)) dut (
        .clock(clock), .reset(reset),
        .in0_paddr(in0_paddr), .in0_psel(in0_psel), .in0_penable(in0_penable),
        .in0_pprot(in0_pprot), .in0_pwrite(in0_pwrite), .in0_pwdata(in0_pwdata),
        .in0_pstrb(in0_pstrb), .in0_pready(in0_pready), .in0_prdata(in0_prdata),
        .in0_pslverr(in0_pslverr),
        .in1_paddr(in1_paddr), .in1_psel(in1_psel), .in1_penable(in1_penable),
        .in1_pprot(in1_pprot), .in1_pwrite(in1_pwrite), .in1_pwdata(in1_pwdata),
        .in1_pstrb(in1_pstrb), .in1_pready(in1_pready), .in1_prdata(in1_prdata),
        .in1_pslverr(in1_pslverr),
        .out_paddr(out_paddr), .out_pprot(out_pprot), .out_pwrite(out_pwrite),
        .out_pwdata(out_pwdata), .out_pstrb(out_pstrb), .out_psel(out_psel),
        .out_penable(out_penable), .out_pready(out_pready), .out_prdata(out_prdata),
        .out_pslverr(out_pslverr)
    );

    function automatic logic [31:0] rdataFn(input logic [31:0] a);
        return a ^ 32'hC3C3_0F0F;
    endfunction

    function automatic logic errFn(input logic [31:0] a);
        return ^a[5:2];
    endfunction

    // Behavioural slave: wait states chosen in SETUP, data driven all through ACCESS.
    always @(negedge clock) begin
        if (out_psel && !out_penable)
            curWait = randomWaits ? int'($urandom_range(0, 3)) : slaveWait;
        if (out_psel && out_penable) begin
            out_prdata  = slaveUseFixed ? slaveFixed : rdataFn(out_paddr);
            out_pslverr = slaveErrMode ? errFn(out_paddr) : 1'b0;
            if (!slaveHang && curWait == 0) begin
                out_pready = 1'b1;
            end else begin
                out_pready = 1'b0;
                if (curWait > 0) curWait--;
            end
        end else begin
            out_pready  = 1'b0;
            out_prdata  = '0;
            out_pslverr = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic driveReq(input bit id, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic write, input logic [3:0] strb, input logic [2:0] prot);
        if (id) begin
            in1_paddr = addr; in1_pwdata = wdata; in1_pwrite = write;
            in1_pstrb = strb; in1_pprot = prot; in1_psel = 1'b1;
        end else begin
            in0_paddr = addr; in0_pwdata = wdata; in0_pwrite = write;
            in0_pstrb = strb; in0_pprot = prot; in0_psel = 1'b1;
        end
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        bit pend0, pend1;
        int served, cyc;
        slaveWait = v.waits;
        if (v.req0) driveReq(0, v.addr0, ~v.addr0, v.write0, 4'hF, 3'd1);
        if (v.req1) driveReq(1, v.addr1, ~v.addr1, v.write1, 4'h3, 3'd2);
        pend0 = v.req0; pend1 = v.req1; served = 0; cyc = 0;
        while ((pend0 || pend1) && cyc < 40) begin
            step();
            cyc++;
            for (int id = 0; id < 2; id++) begin
                if ((id == 0) ? in0_pready : in1_pready) begin
                    checkOutput($sformatf("vec%0d_order%0d", idx, served), id,
                                (served == 0) ? 32'(v.expFirst) : 32'(!v.expFirst));
                    checkOutput($sformatf("vec%0d_latency%0d", idx, served), cyc,
                                (served == 0) ? 2 + v.waits : 5 + 2 * v.waits);
                    checkOutput($sformatf("vec%0d_paddr%0d", idx, served), out_paddr,
                                (id == 1) ? v.addr1 : v.addr0);
                    checkOutput($sformatf("vec%0d_prdata%0d", idx, served),
                                (id == 1) ? in1_prdata : in0_prdata,
                                rdataFn((id == 1) ? v.addr1 : v.addr0));
                    served++;
                    if (id == 0) begin pend0 = 1'b0; in0_psel = 1'b0; end
                    else begin pend1 = 1'b0; in1_psel = 1'b0; end
                    if (!v.bothServe) begin
                        pend0 = 1'b0; pend1 = 1'b0; in0_psel = 1'b0; in1_psel = 1'b0;
                    end
                end
            end
        end
        if (pend0 || pend1) checkOutput($sformatf("vec%0d_budget", idx), 0, 1);
        step();
    endtask

    vec_t vecs[8];
    txn_t q0[$], q1[$];
    int   expIds[$];
    int   order[$];
    int   doneAt[$];

    initial begin
        // Reset state, with a request already present that must be ignored.
        in0_psel = 1'b1;
        #12;
        checkOutput("rst_out_psel", out_psel, 0);
        checkOutput("rst_out_penable", out_penable, 0);
        checkOutput("rst_out_paddr", out_paddr, 0);
        checkOutput("rst_out_pwdata", out_pwdata, 0);
        checkOutput("rst_in0_pready", in0_pready, 0);
        checkOutput("rst_in1_pready", in1_pready, 0);
        checkOutput("rst_in0_prdata", in0_prdata, 0);
        in0_psel = 1'b0;
        step();
        reset = 1'b1;
        step();

        // Arbitration vectors; after reset a tie goes to in0.
        vecs[0] = '{1, 1, 32'h1000_0010, 32'h1000_0020, 1, 1, 0, 1, 0};
        vecs[1] = '{0, 1, 32'h0,         32'h1000_0030, 0, 0, 0, 0, 1};
        vecs[2] = '{1, 1, 32'h1000_0040, 32'h1000_0044, 1, 0, 0, 0, 0};
        vecs[3] = '{1, 1, 32'h1000_0048, 32'h1000_004C, 0, 1, 1, 0, 1};
        vecs[4] = '{1, 0, 32'h1000_0050, 32'h0,         1, 0, 2, 0, 0};
        vecs[5] = '{1, 1, 32'h1000_0054, 32'h1000_0058, 0, 1, 0, 1, 1};
        vecs[6] = '{1, 0, 32'h1000_005C, 32'h0,         0, 0, 1, 0, 0};
        vecs[7] = '{1, 1, 32'h1000_0060, 32'h1000_0064, 1, 1, 0, 0, 1};
        foreach (vecs[i]) applyStimulus(i, vecs[i]);

        // Zero-wait in0 read: SETUP at T+1, ACCESS and completion at T+2.
        slaveWait = 0; slaveUseFixed = 1'b1; slaveFixed = 32'h0000_A5A5;
        driveReq(0, 32'h1000_0008, 32'h0, 0, 4'h0, 3'd0);
        step();
        checkOutput("t1_setup", {out_psel, out_penable}, 2'b10);
        checkOutput("t1_setup_paddr", out_paddr, 32'h1000_0008);
        step();
        checkOutput("t1_access", {out_psel, out_penable}, 2'b11);
        checkOutput("t1_in0_pready", in0_pready, 1);
        checkOutput("t1_in0_prdata", in0_prdata, 32'h0000_A5A5);
        checkOutput("t1_in1_pready", in1_pready, 0);
        in0_psel = 1'b0;
        step();
        checkOutput("t1_idle_psel", out_psel, 0);
        checkOutput("t1_idle_pready", in0_pready, 0);
        slaveUseFixed = 1'b0;

        // Three wait states on an in1 write while in0 waits behind it.
        slaveWait = 3;
        driveReq(1, 32'h1000_0000, 32'h0000_00FF, 1, 4'h1, 3'd2);
        step();
        driveReq(0, 32'h2000_0004, 32'h1234_5678, 1, 4'hF, 3'd0);
        checkOutput("t3_setup", {out_psel, out_penable}, 2'b10);
        for (int a = 0; a < 4; a++) begin
            step();
            checkOutput($sformatf("t3_ctl%0d", a), {out_psel, out_penable}, 2'b11);
            checkOutput($sformatf("t3_paddr%0d", a), out_paddr, 32'h1000_0000);
            checkOutput($sformatf("t3_pwdata%0d", a), out_pwdata, 32'h0000_00FF);
            checkOutput($sformatf("t3_pstrb%0d", a), {out_pwrite, out_pstrb}, 5'h11);
            checkOutput($sformatf("t3_in1_pready%0d", a), in1_pready, (a == 3) ? 1 : 0);
            checkOutput($sformatf("t3_in0_pready%0d", a), {in0_pready, in0_prdata}, 0);
        end
        in0_psel = 1'b0; in1_psel = 1'b0;
        step();
        checkOutput("t3_idle_psel", out_psel, 0);

        // in0 streams three transfers; in1 must get the second slot.
        slaveWait = 0;
        driveReq(0, 32'h3000_0000, 32'h0, 0, 4'h0, 3'd0);
        driveReq(1, 32'h3100_0000, 32'h0, 0, 4'h0, 3'd0);
        begin
            int n0 = 0;
            bit done1 = 1'b0;
            int cyc = 0;
            while ((n0 < 3 || !done1) && cyc < 60) begin
                step();
                cyc++;
                if (in0_pready) begin
                    order.push_back(0); doneAt.push_back(cyc);
                    checkOutput($sformatf("t6_in0_paddr%0d", n0), out_paddr, 32'h3000_0000 + 32'(n0 * 4));
                    n0++;
                    if (n0 < 3) driveReq(0, 32'h3000_0000 + 32'(n0 * 4), 32'h0, 0, 4'h0, 3'd0);
                    else in0_psel = 1'b0;
                end
                if (in1_pready) begin
                    order.push_back(1); doneAt.push_back(cyc);
                    in1_psel = 1'b0; done1 = 1'b1;
                end
            end
            checkOutput("t6_count", order.size(), 4);
            if (order.size() == 4) begin
                checkOutput("t6_order", {order[0][0], order[1][0], order[2][0], order[3][0]}, 4'b0100);
                checkOutput("t6_b2b_spacing", doneAt[3] - doneAt[2], 3);
            end
        end
        step();

        // Hung slave: four waiting ACCESS cycles, then a watchdog abort.
        slaveHang = 1'b1; slaveUseFixed = 1'b1; slaveFixed = 32'hDEAD_BEEF;
        driveReq(0, 32'h1000_000C, 32'h0, 0, 4'h0, 3'd0);
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            checkOutput($sformatf("t4_wait%0d", k), {out_penable, in0_pready}, 2'b10);
        end
        step();
        checkOutput("t4_abort_pready", in0_pready, 1);
        checkOutput("t4_abort_pslverr", in0_pslverr, 1);
        checkOutput("t4_abort_prdata", in0_prdata, 0);
        checkOutput("t4_abort_in1", in1_pready, 0);
        in0_psel = 1'b0;
        step();
        checkOutput("t4_idle", {out_psel, in0_pready}, 2'b00);
        slaveHang = 1'b0; slaveUseFixed = 1'b0;

        // Reset asserted in ACCESS drops the slave controls immediately.
        slaveWait = 3;
        driveReq(1, 32'h1000_0014, 32'h0, 0, 4'h0, 3'd0);
        step();
        step();
        checkOutput("t5_access", {out_psel, out_penable}, 2'b11);
        reset = 1'b0;
        #1;
        checkOutput("t5_async_drop", {out_psel, out_penable, in1_pready}, 3'b000);
        in1_psel = 1'b0;
        step();
        reset = 1'b1;
        slaveWait = 0;
        driveReq(1, 32'h1000_0018, 32'h0, 0, 4'h0, 3'd0);
        step();
        checkOutput("t5_setup", {out_psel, out_penable}, 2'b10);
        step();
        checkOutput("t5_pready", in1_pready, 1);
        checkOutput("t5_prdata", in1_prdata, rdataFn(32'h1000_0018));
        in1_psel = 1'b0;
        step();

        // Randomized: both requesters stream queued transfers, slave waits vary.
        randomWaits = 1'b1; slaveErrMode = 1'b1;
        begin
            int n0 = int'($urandom_range(5, 15));
            int n1 = int'($urandom_range(5, 15));
            int e0, e1, cyc;
            bit lastG;
            for (int i = 0; i < n0; i++)
                q0.push_back('{{4'h4, 20'($urandom), 8'($urandom_range(0, 63) * 4)}, 32'($urandom),
                               1'($urandom), 4'($urandom), 3'($urandom)});
            for (int i = 0; i < n1; i++)
                q1.push_back('{{4'h5, 20'($urandom), 8'($urandom_range(0, 63) * 4)}, 32'($urandom),
                               1'($urandom), 4'($urandom), 3'($urandom)});
            e0 = n0; e1 = n1; lastG = 1'b1;
            while (e0 > 0 || e1 > 0) begin
                bit g;
                g = (e0 > 0 && e1 > 0) ? !lastG : (e1 > 0);
                expIds.push_back(int'(g));
                if (g) e1--; else e0--;
                lastG = g;
            end
            driveReq(0, q0[0].addr, q0[0].wdata, q0[0].write, q0[0].strb, q0[0].prot);
            driveReq(1, q1[0].addr, q1[0].wdata, q1[0].write, q1[0].strb, q1[0].prot);
            cyc = 0;
            while ((q0.size() > 0 || q1.size() > 0) && cyc < 800) begin
                step();
                cyc++;
                checkOutput("rnd_exclusive", {in0_pready, in1_pready} == 2'b11, 0);
                for (int id = 0; id < 2; id++) begin
                    if ((id == 0) ? in0_pready : in1_pready) begin
                        txn_t t;
                        int expId;
                        t = (id == 0) ? q0[0] : q1[0];
                        expId = (expIds.size() > 0) ? expIds.pop_front() : -1;
                        checkOutput("rnd_grant", id, expId);
                        checkOutput("rnd_paddr", out_paddr, t.addr);
                        checkOutput("rnd_ctl", {out_pwrite, out_pstrb, out_pprot},
                                    {t.write, t.strb, t.prot});
                        if (t.write) checkOutput("rnd_pwdata", out_pwdata, t.wdata);
                        checkOutput("rnd_prdata", (id == 0) ? in0_prdata : in1_prdata, rdataFn(t.addr));
                        checkOutput("rnd_pslverr", (id == 0) ? in0_pslverr : in1_pslverr, errFn(t.addr));
                        checkOutput("rnd_other_rdata", (id == 0) ? in1_prdata : in0_prdata, 0);
                        if (id == 0) begin
                            void'(q0.pop_front());
                            if (q0.size() > 0) driveReq(0, q0[0].addr, q0[0].wdata, q0[0].write, q0[0].strb, q0[0].prot);
                            else in0_psel = 1'b0;
                        end else begin
                            void'(q1.pop_front());
                            if (q1.size() > 0) driveReq(1, q1[0].addr, q1[0].wdata, q1[0].write, q1[0].strb, q1[0].prot);
                            else in1_psel = 1'b0;
                        end
                    end
                end
            end
            if (q0.size() > 0 || q1.size() > 0) checkOutput("rnd_budget", 0, 1);
        end
        randomWaits = 1'b0; slaveErrMode = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
